// File: rtl/bus_mon_pkg.sv
// bus_mon_pkg: shared state encoding and index-width helper for the bus result monitor
package bus_mon_pkg;
    typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TIMEOUT} mon_state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bus_mon_if.sv
// bus_mon_if: processor-to-memory store bus as seen by the result monitor
interface bus_mon_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              memwrite;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] writedata;
    modport master (output memwrite, adr, writedata);
    modport slave  (input  memwrite, adr, writedata);
endinterface

// File: rtl/bus_mon_table.sv
// bus_mon_table: expected-store register file, synchronous write and combinational read
module bus_mon_table #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_CHECKS = 4,
    parameter int IDX_W      = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [ADDR_W-1:0] wadr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [ADDR_W-1:0] radr,
    output logic [DATA_W-1:0] rdata
);
    logic [ADDR_W-1:0] adr_mem  [NUM_CHECKS];
    logic [DATA_W-1:0] data_mem [NUM_CHECKS];
    always_ff @(posedge clk) begin
        if (we && int'(widx) < NUM_CHECKS) begin
            adr_mem[widx]  <= wadr;
            data_mem[widx] <= wdata;
        end
    end
    assign radr  = (int'(ridx) < NUM_CHECKS) ? adr_mem[ridx]  : '0;
    assign rdata = (int'(ridx) < NUM_CHECKS) ? data_mem[ridx] : '0;
endmodule

// File: rtl/bus_result_monitor.sv
// bus_result_monitor: ordered expected-store checker on the memory write bus with pass/timeout verdicts
// Optional BUS_MON_FAIL_ON_MISMATCH_EN: a store to the expected address with wrong data ends the run in FAIL.
module bus_result_monitor
    import bus_mon_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_CHECKS     = 4,
    parameter int ADR_SHIFT      = 2,
    parameter int TIMEOUT_CYCLES = 4200,
    parameter int CNT_W          = 32,
    localparam int IDX_W         = idx_w(NUM_CHECKS)
) (
    input  logic              clk,
    input  logic              reset,
    bus_mon_if.slave          bus,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_adr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [IDX_W:0]    cfg_num,
    input  logic              start,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IDX_W:0]    match_count,
    output logic [CNT_W-1:0]  cycle_count
);
    localparam int MC_W = IDX_W + 1;
    mon_state_t state, state_n;
    logic [MC_W-1:0]   num, num_n, mc_n;
    logic [CNT_W-1:0]  cc_n;
    logic [ADDR_W-1:0] exp_adr;
    logic [DATA_W-1:0] exp_data;
    logic addr_eq, data_eq, hit, miss, last, tmo;
    bus_mon_table #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CHECKS(NUM_CHECKS), .IDX_W(IDX_W)
    ) u_table (
        .clk(clk), .we(cfg_we && state != RUN), .widx(cfg_idx), .wadr(cfg_adr), .wdata(cfg_data),
        .ridx(match_count[IDX_W-1:0]), .radr(exp_adr), .rdata(exp_data)
    );
    // X/Z on the bus leaves these compares unknown, so neither hit nor miss fires
    assign addr_eq = (bus.adr >> ADR_SHIFT) == exp_adr;
    assign data_eq = bus.writedata == exp_data;
    assign hit     = (bus.memwrite && addr_eq && data_eq) === 1'b1;
`ifdef BUS_MON_FAIL_ON_MISMATCH_EN
    assign miss    = (bus.memwrite && addr_eq && !data_eq) === 1'b1;
    assign fail    = state == FAIL;
`else
    assign miss    = 1'b0;
    assign fail    = 1'b0;
`endif
    assign last    = match_count + MC_W'(1) == num;
    assign tmo     = (TIMEOUT_CYCLES != 0) && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign done    = state == PASS || state == FAIL || state == TIMEOUT;
    assign pass    = state == PASS;
    assign timeout = state == TIMEOUT;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            num         <= '0;
            match_count <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_n;
            num         <= num_n;
            match_count <= mc_n;
            cycle_count <= cc_n;
        end
    end
    always_comb begin
        state_n = state;
        num_n   = num;
        mc_n    = match_count;
        cc_n    = cycle_count;
        if (state != RUN) begin
            if (start) begin
                num_n   = (cfg_num > MC_W'(NUM_CHECKS)) ? MC_W'(NUM_CHECKS) : cfg_num;
                mc_n    = '0;
                cc_n    = '0;
                state_n = (cfg_num == '0) ? PASS : RUN;
            end
        end else begin
            cc_n    = cycle_count + CNT_W'(cycle_count != '1);
            mc_n    = hit ? match_count + MC_W'(1) : match_count;
            state_n = miss ? FAIL : (hit && last) ? PASS : tmo ? TIMEOUT : RUN;
        end
    end
endmodule

// File: tb/tb_bus_result_monitor.sv
// tb_bus_result_monitor: directed checks of store matching, ordering, timeout, mismatch and reset
module tb_bus_result_monitor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [31:0] cfg_adr = '0;
    logic [31:0] cfg_data = '0;
    logic [2:0]  cfg_num = '0;
    logic        start = 1'b0;
    logic        done, pass, fail, timeout;
    logic [2:0]  match_count;
    logic [31:0] cycle_count;
    int total = 0;
    int bad = 0;

    bus_mon_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    bus_result_monitor #(
        .ADDR_W(32), .DATA_W(32), .NUM_CHECKS(4), .ADR_SHIFT(2), .TIMEOUT_CYCLES(100), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .cfg_num(cfg_num), .start(start),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .match_count(match_count), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = i; cfg_adr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic begin_run(input logic [2:0] n);
        cfg_num = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite = 1'b1; bus.adr = a; bus.writedata = d;
        tick();
        bus.memwrite = 1'b0;
    endtask

    initial begin
        bus.memwrite = 1'b0; bus.adr = '0; bus.writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_mc", match_count, 0);
        chk("rst_cc", cycle_count, 0);
        reset = 1'b0;
        tick();
        // 1) table write and start in the same cycle; single store at cycle 50
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_adr = 32'h6f; cfg_data = 32'h6d73e55f;
        cfg_num = 3'd1; start = 1'b1;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        chk("t1_cc0", cycle_count, 0);
        chk("t1_done0", done, 0);
        repeat (50) tick();
        chk("t1_cc50", cycle_count, 50);
        store(32'h1bc, 32'h6d73e55f);
        chk("t1_pass", pass, 1);
        chk("t1_done", done, 1);
        chk("t1_mc", match_count, 1);
        chk("t1_cc51", cycle_count, 51);
        tick();
        chk("t1_pass_sticky", pass, 1);
        chk("t1_cc_hold", cycle_count, 51);
        // 2) ordered matching: B,A,x,B,C -> hits on A, second B, C
        cfg_write(2'd0, 32'h10, 32'h11111111);
        cfg_write(2'd1, 32'h20, 32'h22222222);
        cfg_write(2'd2, 32'h30, 32'h33333333);
        begin_run(3'd3);
        chk("t2_restart_mc", match_count, 0);
        chk("t2_restart_pass", pass, 0);
        store(32'h80, 32'h22222222);
        chk("t2_b_early", match_count, 0);
        store(32'h40, 32'h11111111);
        chk("t2_a", match_count, 1);
        store(32'h200, 32'h5);
        chk("t2_other", match_count, 1);
        store(32'h80, 32'h22222222);
        chk("t2_b", match_count, 2);
        chk("t2_not_done", done, 0);
        store(32'hc0, 32'h33333333);
        chk("t2_c", match_count, 3);
        chk("t2_pass", pass, 1);
        // 3) timeout after exactly 100 RUN cycles
        begin_run(3'd1);
        repeat (99) tick();
        chk("t3_cc99", cycle_count, 99);
        chk("t3_to_early", timeout, 0);
        tick();
        chk("t3_timeout", timeout, 1);
        chk("t3_done", done, 1);
        chk("t3_pass", pass, 0);
        chk("t3_cc100", cycle_count, 100);
        repeat (5) tick();
        chk("t3_cc_hold", cycle_count, 100);
        chk("t3_to_sticky", timeout, 1);
        // 4) final hit in the timeout cycle wins
        begin_run(3'd1);
        chk("t4_to_cleared", timeout, 0);
        repeat (99) tick();
        store(32'h40, 32'h11111111);
        chk("t4_pass", pass, 1);
        chk("t4_timeout", timeout, 0);
        chk("t4_cc", cycle_count, 100);
        // zero active entries passes immediately
        begin_run(3'd0);
        chk("tz_pass", pass, 1);
        chk("tz_mc", match_count, 0);
        chk("tz_cc", cycle_count, 0);
        // 5) wrong data at the expected address
        cfg_write(2'd0, 32'h6f, 32'h6d73e55f);
        begin_run(3'd1);
        store(32'h1bc, 32'hdeadbeef);
`ifdef BUS_MON_FAIL_ON_MISMATCH_EN
        chk("t5_fail", fail, 1);
        chk("t5_done", done, 1);
        chk("t5_pass", pass, 0);
`else
        chk("t5_fail_off", fail, 0);
        chk("t5_done_off", done, 0);
        chk("t5_mc_off", match_count, 0);
        store(32'h1bc, 32'h6d73e55f);
        chk("t5_pass_off", pass, 1);
        chk("t5_mc1_off", match_count, 1);
`endif
        // 6) async reset mid-run; RUN-time table write is dropped
        cfg_write(2'd0, 32'h10, 32'h11111111);
        cfg_write(2'd1, 32'h20, 32'h22222222);
        begin_run(3'd2);
        store(32'h40, 32'h11111111);
        chk("t6_mc1", match_count, 1);
        cfg_write(2'd1, 32'h55, 32'h99);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_mc", match_count, 0);
        chk("t6_rst_cc", cycle_count, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_pass", pass, 0);
        chk("t6_rst_timeout", timeout, 0);
        tick();
        reset = 1'b0;
        tick();
        begin_run(3'd2);
        chk("t6_re_mc0", match_count, 0);
        chk("t6_re_cc0", cycle_count, 0);
        store(32'h40, 32'h11111111);
        chk("t6_re_mc1", match_count, 1);
        store(32'h80, 32'h22222222);
        chk("t6_re_mc2", match_count, 2);
        chk("t6_re_pass", pass, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
